// File: rtl/led_flow_pkg.sv
// Shared mode encodings and start-position helper for the LED sequencer.
package led_flow_pkg;

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_PING = 2'b10,
    MODE_FILL = 2'b11
  } mode_e;

  function automatic int unsigned start_pos(input logic [1:0] mode, input int unsigned n_led);
    return (mode == MODE_SHR) ? (n_led - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/led_flow_prescaler.sv
// Programmable step prescaler: one-cycle tick every BASE_DIV<<speed cycles while enabled.
// Holds its count while paused; i_clr restarts the interval and suppresses the tick.
module led_flow_prescaler #(
  parameter int BASE_DIV = 16384,
  parameter int CNT_W    = 22
) (
  input  logic       clk_50M,
  input  logic       reset_n,
  input  logic       i_enable,
  input  logic       i_clr,
  input  logic [2:0] i_speed,
  output logic       o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_lim;
  logic             w_hit;

  assign w_lim = (CNT_W'(BASE_DIV) << i_speed) - CNT_W'(1);
  // >= so that a speed decrease mid-interval ticks immediately
  assign w_hit  = (r_cnt >= w_lim);
  assign o_tick = i_enable & ~i_clr & w_hit;

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_hit ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_flow_ctrl.sv
// Multi-mode LED sequencer: position/direction FSM advanced by the prescaler tick.
// led is registered from (mode_q, pos); wrap is delayed to line up with the new led.
module led_flow_ctrl
  import led_flow_pkg::*;
#(
  parameter int N_LED    = 10,
  parameter int BASE_DIV = 16384,
  parameter int CNT_W    = 22
) (
  input  logic             clk_50M,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [2:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             wrap
);

  localparam int PW = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_LED - 1);

  mode_e            r_mode_q, w_mode_nxt;
  logic [PW-1:0]    r_pos, w_pos_nxt;
  logic             r_up, w_up_nxt;
  logic             r_wrap_p, r_wrap;
  logic [N_LED-1:0] r_led, w_led_nxt;
  logic [N_LED:0]   w_one;
  logic             w_tick, w_mode_chg, w_wrap_evt;

  assign w_mode_chg = (mode != r_mode_q);

  led_flow_prescaler #(
    .BASE_DIV (BASE_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk_50M  (clk_50M),
    .reset_n  (reset_n),
    .i_enable (enable),
    .i_clr    (w_mode_chg),
    .i_speed  (speed),
    .o_tick   (w_tick)
  );

  always_comb begin
    w_mode_nxt = r_mode_q;
    w_pos_nxt  = r_pos;
    w_up_nxt   = r_up;
    w_wrap_evt = 1'b0;
    if (w_mode_chg) begin
      w_mode_nxt = mode_e'(mode);
      w_pos_nxt  = PW'(start_pos(mode, N_LED));
      w_up_nxt   = 1'b1;
    end else if (w_tick) begin
      case (r_mode_q)
        MODE_SHR: begin
          w_pos_nxt  = (r_pos == '0) ? LAST : r_pos - PW'(1);
          w_wrap_evt = (r_pos == '0);
        end
        MODE_PING: begin
          // Reversal steps away from the end so end positions are shown once
          if (r_up) begin
            if (r_pos == LAST) begin
              w_pos_nxt  = LAST - PW'(1);
              w_up_nxt   = 1'b0;
              w_wrap_evt = (LAST == PW'(1));
            end else begin
              w_pos_nxt = r_pos + PW'(1);
            end
          end else if (r_pos == '0) begin
            w_pos_nxt = PW'(1);
            w_up_nxt  = 1'b1;
          end else begin
            w_pos_nxt  = r_pos - PW'(1);
            w_wrap_evt = (r_pos == PW'(1));
          end
        end
        default: begin
          w_pos_nxt  = (r_pos == LAST) ? '0 : r_pos + PW'(1);
          w_wrap_evt = (r_pos == LAST);
        end
      endcase
    end
  end

  assign w_one     = (N_LED + 1)'(1) << r_pos;
  assign w_led_nxt = (r_mode_q == MODE_FILL) ? N_LED'((w_one << 1) - (N_LED + 1)'(1))
                                             : N_LED'(w_one);

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_q <= MODE_SHL;
      r_pos    <= '0;
      r_up     <= 1'b1;
      r_led    <= '0;
      r_wrap_p <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_mode_q <= w_mode_nxt;
      r_pos    <= w_pos_nxt;
      r_up     <= w_up_nxt;
      r_led    <= w_led_nxt;
      r_wrap_p <= w_wrap_evt;
      r_wrap   <= r_wrap_p;
    end
  end

  assign led  = r_led;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Scoreboard bench: a step-index reference model predicts {wrap, led} each cycle; a negedge monitor compares.
module tb_led_flow_ctrl;

  localparam int N    = 10;
  localparam int BASE = 4;

  logic         clk_50M;
  logic         reset_n;
  logic         enable;
  logic [1:0]   mode;
  logic [2:0]   speed;
  logic [N-1:0] led;
  logic         wrap;

  int total = 0;
  int bad   = 0;

  logic [N:0] sb[$];

  led_flow_ctrl #(.N_LED(N), .BASE_DIV(BASE), .CNT_W(8)) dut (
    .clk_50M (clk_50M),
    .reset_n (reset_n),
    .enable  (enable),
    .mode    (mode),
    .speed   (speed),
    .led     (led),
    .wrap    (wrap)
  );

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  // Reference: position derived from step count k since the mode's start.
  function automatic int period_of(input int m);
    return (m == 2) ? 2 * (N - 1) : N;
  endfunction

  function automatic int pos_of(input int m, input int k);
    if (m == 1) return N - 1 - k;
    if (m == 2) return (k < N) ? k : 2 * (N - 1) - k;
    return k;
  endfunction

  function automatic logic [N-1:0] led_of(input int m, input int k);
    int p;
    p = pos_of(m, k);
    if (m == 3) return N'((1 << (p + 1)) - 1);
    return N'(1 << p);
  endfunction

  int m_mq = 0, m_k = 0, m_cnt = 0;
  bit m_wp = 0;

  always @(posedge clk_50M) begin
    bit ev;
    ev = 1'b0;
    if (!reset_n) begin
      m_mq = 0; m_k = 0; m_cnt = 0; m_wp = 0;
      sb.push_back({1'b0, {N{1'b0}}});
    end else begin
      sb.push_back({m_wp, led_of(m_mq, m_k)});
      if (int'(mode) != m_mq) begin
        m_mq = int'(mode); m_k = 0; m_cnt = 0;
      end else if (enable) begin
        if (m_cnt >= BASE * (1 << speed) - 1) begin
          m_cnt = 0;
          m_k   = (m_k + 1) % period_of(m_mq);
          ev    = (m_k == 0);
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      m_wp = ev;
    end
  end

  always @(negedge clk_50M) begin
    logic [N:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if ({wrap, led} !== e) begin
        bad++;
        $display("FAIL sb t=%0t got led=%h wrap=%b want led=%h wrap=%b",
                 $time, led, wrap, e[N-1:0], e[N]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic wait_led(input logic [N-1:0] v, input string nm);
    int i;
    i = 0;
    while (led !== v && i < 200) begin
      @(negedge clk_50M);
      i++;
    end
    total++;
    if (led !== v) begin
      bad++;
      $display("FAIL %s timeout got led=%h want led=%h", nm, led, v);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk_50M);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (led !== '0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got led=%h wrap=%b want led=0 wrap=0", led, wrap);
    end
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    mode    = 2'b00;
    speed   = 3'd0;
    step(3);
    reset_n = 1'b1;
    step(90);
    mode = 2'b10; step(80);
    mode = 2'b11; step(50);
    mode = 2'b00; step(6);
    speed = 3'd3; step(40);
    speed = 3'd3; step(21);
    speed = 3'd0; step(12);
    wait_led(N'(16), "wait_0x010");
    enable = 1'b0; step(100);
    enable = 1'b1; step(30);
    wait_led(N'(8), "wait_0x008");
    mode = 2'b01; step(20);
    pulse_reset();
    step(20);
    mode = 2'b01; step(30);
    pulse_reset();
    step(20);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) speed = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 1499) == 0) pulse_reset();
      else step(1);
    end
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_flow_ctrl.md
# led_flow_ctrl

- Parametrised, multi-mode LED sequencer for board bring-up and selection-machine status display.
- Drives an N-bit LED bank through one of four patterns, advanced by an on-chip programmable prescaler.
- Supports run/pause, a live speed select and a wrap strobe for software or test sequencing.
- Fully synchronous to clk_50M: no derived or ripple clocks.

## Interface
Parameters:
- N_LED, 10, LED count; legal range 2..32.
- BASE_DIV, 16384, clk_50M cycles per step at speed 0; must be ≥ 1.
- CNT_W, 22, prescaler width; must hold BASE_DIV·2^7 − 1.

Ports:
- clk_50M  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = sequence runs, 0 = pattern frozen
- mode  in  2  00 shift-left, 01 shift-right, 10 ping-pong, 11 fill
- speed  in  3  step period = BASE_DIV·2^speed cycles
- led  out  N_LED  registered LED drive, 1 = lit
- wrap  out  1  one-cycle strobe when the pattern returns to its start position

## Operation
- Prescaler `cnt`:
  - Limit L = (BASE_DIV << speed) − 1.
  - While enable = 1: if cnt ≥ L, then tick = 1 and cnt ← 0; else cnt ← cnt + 1.
  - Comparison is ≥, so lowering speed mid-count ticks on the next cycle.
  - While enable = 0: cnt holds and tick = 0.
- Position `pos` (0..N_LED−1) and direction `up` advance only on tick.
- Mode behaviour:
  - Shift-left: pos 0→1→…→N−1→0. led = 1<<pos.
  - Shift-right: pos N−1→…→0→N−1. led = 1<<pos.
  - Ping-pong: pos rises 0→N−1, then falls →0, then rises again. End positions are not repeated: sequence 0,1,…,N−1,N−2,…,1,0,1,… led = 1<<pos.
  - Fill: pos 0→N−1→0. led = (2<<pos) − 1 (thermometer), so all bits are lit at pos = N−1.
- Start position is N−1 for shift-right, 0 for all other modes.
- wrap = 1 for exactly one cycle, on the tick that moves pos onto the start position.
  - Ping-pong: wrap fires on return to 0. The ping-pong end reversal does not wrap.
- Mode change: any cycle where mode differs from the registered mode_q:
  - mode_q ← mode, pos ← new start, up ← 1, cnt ← 0.
  - No wrap, no tick that cycle. Takes priority over a coincident tick.
- enable = 0 freezes pos, up, cnt and led. wrap = 0. A mode change is still applied while paused.
- led is a pure registered function of (mode_q, pos), updated every cycle.

## Timing
- Reset (async assert, sync to clk_50M via the flop): cnt = 0, pos = 0, up = 1, mode_q = 00, led = 0, wrap = 0.
- The first rising edge after reset release loads mode_q and the start position. The mode path applies when mode ≠ 00.
- led shows the start pattern one cycle after mode_q/pos settle: latency 1 cycle from pos to led.
- Step interval is exactly BASE_DIV·2^speed cycles with constant speed and enable = 1. The first step after reset or mode change comes BASE_DIV·2^speed cycles after cnt restarts.
- wrap is asserted in the same cycle the new led value appears.
- Reset asserted mid-sequence clears everything immediately. The sequence restarts from the start position; there is no residual prescaler count.

## Structure
- Package led_flow_pkg holds:
  - Mode constants MODE_SHL, MODE_SHR, MODE_PING, MODE_FILL (2-bit).
  - The function start_pos(mode, N_LED).
- Sub-module led_flow_prescaler (clk_50M, reset_n, enable, speed → tick), parametrised by BASE_DIV and CNT_W. It is reusable for other display blocks.
- Top level holds the pos/up/mode_q FSM and the led/wrap output registers.

## Test plan
All scenarios use BASE_DIV = 4 and N_LED = 10.
- Reset, mode 00, speed 0, enable 1 → led = 0x001. It becomes 0x002 after 4 cycles, then 0x004, … 0x200, 0x001. wrap is pulsed with 0x001 every 40 cycles.
- Mode 10 → led steps 0x001…0x200, 0x100…0x001. wrap fires once per 18 steps. 0x200 is held for one step only.
- Mode 11 → led = 0x001, 0x003, 0x007, … 0x3FF, 0x001. wrap fires on the return to 0x001.
- Speed 0→3 mid-count → the next interval is 32 cycles. Speed 3→0 with cnt = 20 → tick on the next cycle, then a 4-cycle interval.
- enable low for 100 cycles at led = 0x010 → led holds 0x010 with no wrap. The step resumes at the remaining count.
- Mode 00→01 at led = 0x008 → the next led = 0x200, with no wrap. reset_n pulsed mid-sequence → led = 0 immediately, then the start pattern.
